sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Shares the single-port MiST SDRAM controller among three requesters: port 0 (host CPU / MPU-401 register side, highest priority), port 1 (sample/wavetable fetch) and port 2 (loader / SD-to-RAM copy).
- Performs one SDRAM access per clkref slot, aligned to the controller's 8-clock cycle.
- Holds the controller's address, data and command inputs stable for the whole slot, captures read data and returns a one-clock ack.
- Guarantees refresh by forcing idle slots, during which the controller issues AUTO_REFRESH.

Parameters:
- DATA_PHASE, 6: clocks after the slot start at which mem_dout is captured and ack pulses; legal range 1..7.
- REFRESH_SLOTS, 32: maximum number of consecutive busy slots; the next slot is then forced idle. Legal range 1..255.

Ports:
- clk  in  1  SDRAM clock; the same clock as the controller.
- reset_n  in  1  Asynchronous, active-low reset.
- clkref  in  1  Slot reference strobe; the same signal fed to the controller.
- pN_req  in  1  Request from port N (N=0,1,2), level-sensitive.
- pN_we  in  1  1 = write, 0 = read.
- pN_addr  in  22  Word address.
- pN_din  in  16  Write data.
- pN_ds  in  2  Byte strobes {hi,lo}.
- pN_ack  out  1  One-clock pulse when port N's access completes.
- pN_dout  out  16  Read data, held until the next read ack on that port.
- mem_addr  out  22  To controller addr.
- mem_din  out  16  To controller din.
- mem_ds  out  2  To controller ds.
- mem_oe  out  1  To controller oe.
- mem_we  out  1  To controller we.
- mem_dout  in  16  From controller dout.
- grant  out  2  Port owning the current slot; 3 = idle.

Behaviour:
- Slot start: the clk cycle in which clkref is 1 and the registered clkref_d is 0. A phase counter resets to 0 there and increments each clk, saturating at 7.
- Arbitration happens only at slot start; req is sampled there and nowhere else.
- Priority order:
  - Forced-idle, if pending, wins over everything.
  - Otherwise p0_req wins.
  - Otherwise ports 1 and 2 are served round-robin. The rr pointer names the preferred port. If only one of ports 1/2 requests, it wins regardless of rr. After port 1 or 2 is granted, rr points to the other port. A grant to port 0 leaves rr unchanged.
- On grant: mem_addr/mem_din/mem_ds are registered from the winner. The winner's pN_we drives mem_we, and its inverse drives mem_oe. grant is set to the port index. All of these are held unchanged until the next slot start.
- No grant (idle or forced idle): mem_oe=0, mem_we=0, grant=3. mem_addr/mem_din/mem_ds hold their previous values.
- Completion at phase == DATA_PHASE with grant != 3:
  - A read registers mem_dout into pN_dout of the granted port.
  - A read or write pulses pN_ack high for exactly 1 clk.
  - Other ports' pN_dout are unchanged.
- Requester rule: keep req and its address/data/strobe/we inputs stable from assertion until ack. Drop req before the next slot start, or it is treated as a new request.
- Refresh counter (8 bit):
  - Increments at each busy slot start.
  - Clears at each idle slot start.
  - When the count equals REFRESH_SLOTS at a slot start, that slot is forced idle and the counter clears.
- clkref absent: no slot starts, outputs hold and no acks are issued. A clkref held high produces only one slot start.
- Reset (async, any phase):
  - mem_oe=0, mem_we=0, mem_addr=0, mem_din=0, mem_ds=0.
  - grant=3, all pN_ack=0, all pN_dout=0.
  - rr=port 1, refresh counter=0, phase=7, clkref_d=0.
  - An access in flight is abandoned with no ack; requesters re-request after reset.
  - After reset release the first arbitration is at the next clkref rising edge.

Test Plan:
- Single read: p1 read at addr 0x012345, mem_dout=0xBEEF -> mem_oe=1, mem_addr=0x012345 held for all 8 clks. p1_ack pulses at phase 6. p1_dout=0xBEEF. grant=1.
- Write: p0 write addr 0x3FFFFF, din 0xA55A, ds=2'b10 -> mem_we=1, mem_oe=0, mem_din=0xA55A, mem_ds=2'b10 for the slot. p0_ack pulses. p0_dout unchanged.
- Contention: p0, p1 and p2 held requesting with each dropping req after its ack and re-raising it -> grant sequence 0,0,0…. Then drop p0 permanently -> grant alternates 1,2,1,2 starting with 1 after reset.
- Refresh starvation: p1 requests continuously with REFRESH_SLOTS=4 -> grant pattern 1,1,1,1,3 repeating, with mem_oe=0 in each idle slot.
- Reset mid-slot: assert reset_n=0 at phase 3 of a p2 read -> mem_oe drops in the same cycle, no p2_ack. After release and a new request, a normal read completes with rr=1.
- Back-to-back and hold: p1 then p2 reads returning 0x1111 and 0x2222 -> p1_dout keeps 0x1111 while p2_dout is updated to 0x2222. No ack on a non-granted port.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single-port MiST SDRAM controller between the host
// CPU side (port 0, highest priority), the sample fetcher (port 1) and the
// loader (port 2). One access is made per clkref slot. Ports 1 and 2 share
// round-robin, and an idle slot is forced periodically so refresh is never starved.
module sdram_arbiter #(
    parameter int DATA_PHASE    = 6,
    parameter int REFRESH_SLOTS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clkref,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [21:0] p0_addr,
    input  logic [15:0] p0_din,
    input  logic [1:0]  p0_ds,
    output logic        p0_ack,
    output logic [15:0] p0_dout,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [21:0] p1_addr,
    input  logic [15:0] p1_din,
    input  logic [1:0]  p1_ds,
    output logic        p1_ack,
    output logic [15:0] p1_dout,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [21:0] p2_addr,
    input  logic [15:0] p2_din,
    input  logic [1:0]  p2_ds,
    output logic        p2_ack,
    output logic [15:0] p2_dout,

    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic [15:0] mem_dout,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        GRANT_P0   = 2'd0,
        GRANT_P1   = 2'd1,
        GRANT_P2   = 2'd2,
        GRANT_IDLE = 2'd3
    } grant_t;

    localparam logic [2:0] DATA_PHASE_C  = 3'(DATA_PHASE);
    localparam logic [7:0] REFRESH_LIMIT = 8'(REFRESH_SLOTS);

    logic        clkref_d;
    logic        slot_start;
    logic [2:0]  phase;
    logic [2:0]  cur_phase;
    logic        access_open;
    logic        complete;
    logic        force_idle;
    logic        rr_p2;
    logic [7:0]  refresh_cnt;
    logic [2:0]  ack_q;
    grant_t      grant_q;
    grant_t      winner;
    logic [21:0] win_addr;
    logic [15:0] win_din;
    logic [1:0]  win_ds;
    logic        win_we;

    // Slot detection and arbitration; the slot-start cycle itself counts as phase 0
    always_comb begin
        slot_start = clkref & ~clkref_d;
        cur_phase  = slot_start ? 3'd0 : phase;
        complete   = access_open && !slot_start && (phase == DATA_PHASE_C);
        force_idle = (refresh_cnt == REFRESH_LIMIT);
        winner     = GRANT_IDLE;
        if (!force_idle) begin
            if (p0_req)
                winner = GRANT_P0;
            else if (p1_req && p2_req)
                winner = rr_p2 ? GRANT_P2 : GRANT_P1;
            else if (p1_req)
                winner = GRANT_P1;
            else if (p2_req)
                winner = GRANT_P2;
        end
    end

    // Steer the winning port's request fields toward the controller registers
    always_comb begin
        win_addr = p0_addr;
        win_din  = p0_din;
        win_ds   = p0_ds;
        win_we   = p0_we;
        case (winner)
            GRANT_P1: begin
                win_addr = p1_addr;
                win_din  = p1_din;
                win_ds   = p1_ds;
                win_we   = p1_we;
            end
            GRANT_P2: begin
                win_addr = p2_addr;
                win_din  = p2_din;
                win_ds   = p2_ds;
                win_we   = p2_we;
            end
            default: ;
        endcase
    end

    // Track the clkref edge and the in-slot phase, saturating at 7 when clkref stops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkref_d <= 1'b0;
            phase    <= 3'd7;
        end else begin
            clkref_d <= clkref;
            phase    <= (cur_phase == 3'd7) ? 3'd7 : 3'(cur_phase + 3'd1);
        end
    end

    // At each slot start, latch the winner's command and update refresh and round-robin state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= GRANT_IDLE;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_ds      <= '0;
            mem_oe      <= 1'b0;
            mem_we      <= 1'b0;
            access_open <= 1'b0;
            refresh_cnt <= '0;
            rr_p2       <= 1'b0;
        end else if (slot_start) begin
            grant_q <= winner;
            if (winner != GRANT_IDLE) begin
                mem_addr    <= win_addr;
                mem_din     <= win_din;
                mem_ds      <= win_ds;
                mem_we      <= win_we;
                mem_oe      <= ~win_we;
                access_open <= 1'b1;
                refresh_cnt <= 8'(refresh_cnt + 8'd1);
            end else begin
                mem_we      <= 1'b0;
                mem_oe      <= 1'b0;
                access_open <= 1'b0;
                refresh_cnt <= '0;
            end
            if (winner == GRANT_P1)
                rr_p2 <= 1'b1;
            else if (winner == GRANT_P2)
                rr_p2 <= 1'b0;
        end else if (complete) begin
            access_open <= 1'b0;
        end
    end

    // Finish the access: pulse the owner's ack and capture read data for that port only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q   <= 3'b000;
            p0_dout <= '0;
            p1_dout <= '0;
            p2_dout <= '0;
        end else begin
            ack_q <= 3'b000;
            if (complete) begin
                case (grant_q)
                    GRANT_P0: begin
                        ack_q <= 3'b001;
                        if (!mem_we) p0_dout <= mem_dout;
                    end
                    GRANT_P1: begin
                        ack_q <= 3'b010;
                        if (!mem_we) p1_dout <= mem_dout;
                    end
                    GRANT_P2: begin
                        ack_q <= 3'b100;
                        if (!mem_we) p2_dout <= mem_dout;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign grant  = grant_q;
    assign p0_ack = ack_q[0];
    assign p1_ack = ack_q[1];
    assign p2_ack = ack_q[2];

endmodule
